// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_arbiter_if
//
// One picorv32-style memory port. The same bundle is used on both sides of
// the arbiter: each requesting master talks to the arbiter through one of
// these, and the arbiter talks to the memory/bus fabric through another.
//
// Signals:
//   valid  request outstanding; held until ready is seen
//   instr  instruction-fetch qualifier
//   addr   32-bit byte address, word aligned
//   wdata  32-bit write data
//   wstrb  byte write strobes; 4'b0000 means read
//   ready  transaction complete, single-cycle pulse
//   rdata  read data, valid while ready is high
//
// Modports:
//   master  the side that issues requests (drives valid/instr/addr/wdata/wstrb)
//   slave   the side that answers them (drives ready/rdata)
// ----------------------------------------------------------------------------
interface mem_arbiter_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output valid,
        output instr,
        output addr,
        output wdata,
        output wstrb,
        input  ready,
        input  rdata
    );

    modport slave (
        input  valid,
        input  instr,
        input  addr,
        input  wdata,
        input  wstrb,
        output ready,
        output rdata
    );
endinterface : mem_arbiter_if

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one picorv32-style memory port between two masters: the CPU core
// (m0) and a second requester such as a DMA engine or debug loader (m1).
// Exactly one transaction is outstanding at a time. When both masters ask
// in the same IDLE cycle, the one that was not granted last wins
// (round-robin). A watchdog returns ERR_DATA with a timeout pulse if the
// downstream leaves a granted request unanswered for too long.
//
// Parameters:
//   TIMEOUT   BUSY cycles without mem.ready before the transaction is aborted;
//             0 disables the watchdog. The abort lands in BUSY cycle
//             TIMEOUT+1.
//   ERR_DATA  read data handed back to the master on an aborted transaction
//
// Ports:
//   clk      single clock, all state updates on its rising edge
//   reset    asynchronous, active-low reset (low = in reset)
//   m0, m1   slave-side ports facing the two masters
//   mem      master-side port facing the memory/bus fabric
//   timeout  high in the cycle an aborted transaction is returned
//   busy     registered: the arbiter currently holds a grant
//
// Timing:
//   - A request sampled in IDLE at edge N shows up on mem.valid in cycle N+1.
//   - m*.ready and m*.rdata are combinational from mem.ready / mem.rdata.
//   - Every transaction is followed by one IDLE cycle, so a zero-wait
//     downstream sees at most one transaction every two cycles.
//   - While IDLE (and therefore while in reset) every output is zero.
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter logic [15:0] TIMEOUT  = 16'd1024,
    parameter logic [31:0] ERR_DATA = 32'hdead_beef
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    mem_arbiter_if.master mem,
    output logic          timeout,
    output logic          busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;          // 0 = m0 owns the port, 1 = m1
    logic        last_grant_q, last_grant_d;
    logic [15:0] wd_cnt_q, wd_cnt_d;        // BUSY cycles spent without mem.ready

    // Request fields of whichever master currently holds the grant.
    logic        sel_valid;
    logic        sel_instr;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;

    // Response for the granted master before it is steered to m0 or m1.
    logic        rsp_ready;
    logic [31:0] rsp_rdata;

    logic        abort;

    always_comb begin
        if (grant_q) begin
            sel_valid = m1.valid;
            sel_instr = m1.instr;
            sel_addr  = m1.addr;
            sel_wdata = m1.wdata;
            sel_wstrb = m1.wstrb;
        end else begin
            sel_valid = m0.valid;
            sel_instr = m0.instr;
            sel_addr  = m0.addr;
            sel_wdata = m0.wdata;
            sel_wstrb = m0.wstrb;
        end
    end

    // A completion arriving in the very cycle the watchdog expires is taken
    // as a normal completion, hence the !mem.ready term.
    assign abort = (TIMEOUT != 16'd0) && (wd_cnt_q == TIMEOUT) && !mem.ready;

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written in this block gets a default before any
        // branch; a path that left one unassigned would infer a latch.
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wd_cnt_d     = wd_cnt_q;

        mem.valid    = 1'b0;
        mem.instr    = 1'b0;
        mem.addr     = 32'h0;
        mem.wdata    = 32'h0;
        mem.wstrb    = 4'h0;

        rsp_ready    = 1'b0;
        rsp_rdata    = 32'h0;
        timeout      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (m0.valid || m1.valid) begin
                    // On a tie the master that did not win last time goes
                    // first; otherwise the single requester is granted.
                    grant_d      = (m0.valid && m1.valid) ? ~last_grant_q : m1.valid;
                    last_grant_d = grant_d;
                    wd_cnt_d     = 16'd0;
                    state_d      = BUSY;
                end
            end

            BUSY: begin
                mem.valid = sel_valid && !abort;
                mem.instr = sel_instr;
                mem.addr  = sel_addr;
                mem.wdata = sel_wdata;
                mem.wstrb = sel_wstrb;

                if (!sel_valid) begin
                    // Master withdrew its request before completion: release
                    // the port silently, no ready pulse.
                    state_d = IDLE;
                end else if (mem.ready) begin
                    rsp_ready = 1'b1;
                    rsp_rdata = mem.rdata;
                    state_d   = IDLE;
                end else if (abort) begin
                    rsp_ready = 1'b1;
                    rsp_rdata = ERR_DATA;
                    timeout   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // The ungranted master always sees ready=0 and rdata=0; rsp_* is already
    // zero whenever the arbiter is IDLE.
    always_comb begin
        m0.ready = rsp_ready && !grant_q;
        m0.rdata = grant_q ? 32'h0 : rsp_rdata;
        m1.ready = rsp_ready && grant_q;
        m1.rdata = grant_q ? rsp_rdata : 32'h0;
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;  // makes m0 win the first tie after reset
            wd_cnt_q     <= 16'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wd_cnt_q     <= wd_cnt_d;
        end
    end

    assign busy = (state_q == BUSY);

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter (TIMEOUT overridden to 4). Two master
// agents and a downstream responder are driven from plain variables; a
// transaction-level reference model (who owns the port, who won last, how
// many cycles the current transaction has been waiting) predicts every
// output every cycle. Directed scenarios come first, then a randomized run.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam logic [15:0] TO  = 16'd4;
    localparam logic [31:0] ERR = 32'hdead_beef;

    logic clk = 1'b0;
    logic reset;
    logic timeout;
    logic busy;

    mem_arbiter_if m0_bus ();
    mem_arbiter_if m1_bus ();
    mem_arbiter_if mem_bus ();

    mem_arbiter #(
        .TIMEOUT  (TO),
        .ERR_DATA (ERR)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m0      (m0_bus),
        .m1      (m1_bus),
        .mem     (mem_bus),
        .timeout (timeout),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Agents: master requests and downstream response
    // ------------------------------------------------------------------------
    logic        a_valid   [2];
    logic        a_instr   [2];
    logic [31:0] a_addr    [2];
    logic [31:0] a_wdata   [2];
    logic [3:0]  a_wstrb   [2];
    logic        a_reissue [2];   // re-raise the same request right after ready

    logic        mem_ready_r;
    logic [31:0] mem_rdata_r;

    assign m0_bus.valid  = a_valid[0];
    assign m0_bus.instr  = a_instr[0];
    assign m0_bus.addr   = a_addr[0];
    assign m0_bus.wdata  = a_wdata[0];
    assign m0_bus.wstrb  = a_wstrb[0];
    assign m1_bus.valid  = a_valid[1];
    assign m1_bus.instr  = a_instr[1];
    assign m1_bus.addr   = a_addr[1];
    assign m1_bus.wdata  = a_wdata[1];
    assign m1_bus.wstrb  = a_wstrb[1];
    assign mem_bus.ready = mem_ready_r;
    assign mem_bus.rdata = mem_rdata_r;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    int owner      = -1;   // -1: nobody holds the port
    int prev_owner = 1;    // winner of the most recent grant
    int age        = 0;    // cycles the current owner has waited so far

    logic        e_mem_valid, e_instr, e_timeout, e_busy;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic        e_ready [2];
    logic [31:0] e_rdata [2];

    // Observed completions (taken from the DUT) and last-cycle snapshot.
    int          obs_who  [$];
    logic [31:0] obs_data [$];
    logic        obs_to   [$];
    logic [31:0] obs_addr [$];

    logic        s_mem_valid, s_instr, s_timeout, s_busy, s_ready0;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void predict();
        logic v;
        logic expired;
        e_mem_valid = 1'b0; e_instr = 1'b0; e_timeout = 1'b0; e_busy = 1'b0;
        e_addr = 32'h0; e_wdata = 32'h0; e_wstrb = 4'h0;
        for (int i = 0; i < 2; i++) begin
            e_ready[i] = 1'b0;
            e_rdata[i] = 32'h0;
        end
        if (owner >= 0) begin
            v       = a_valid[owner];
            expired = (TO != 16'd0) && (age == int'(TO)) && !mem_ready_r;
            e_busy      = 1'b1;
            e_instr     = a_instr[owner];
            e_addr      = a_addr[owner];
            e_wdata     = a_wdata[owner];
            e_wstrb     = a_wstrb[owner];
            e_mem_valid = v && !expired;
            if (v && mem_ready_r) begin
                e_ready[owner] = 1'b1;
                e_rdata[owner] = mem_rdata_r;
            end else if (v && expired) begin
                e_ready[owner] = 1'b1;
                e_rdata[owner] = ERR;
                e_timeout      = 1'b1;
            end
        end
    endfunction

    function automatic void advance();
        if (owner < 0) begin
            if (a_valid[0] || a_valid[1]) begin
                if (a_valid[0] && a_valid[1]) owner = 1 - prev_owner;
                else                          owner = a_valid[1] ? 1 : 0;
                prev_owner = owner;
                age        = 0;
            end
        end else if (!a_valid[owner] || e_ready[owner]) begin
            owner = -1;
        end else begin
            age++;
        end
    endfunction

    function automatic logic [31:0] ctl_now();
        return {22'd0, mem_bus.valid, mem_bus.instr, mem_bus.wstrb,
                m0_bus.ready, m1_bus.ready, timeout, busy};
    endfunction

    // One clock cycle: inputs are already set (posedge+1); compare at the
    // negedge, then advance the model and the agents after the next posedge.
    task automatic step();
        predict();
        @(negedge clk);
        check("ctl", ctl_now(), {22'd0, e_mem_valid, e_instr, e_wstrb,
                                 e_ready[0], e_ready[1], e_timeout, e_busy});
        check("mem_addr",  mem_bus.addr,  e_addr);
        check("mem_wdata", mem_bus.wdata, e_wdata);
        check("m0_rdata",  m0_bus.rdata,  e_rdata[0]);
        check("m1_rdata",  m1_bus.rdata,  e_rdata[1]);
        s_mem_valid = mem_bus.valid;  s_instr = mem_bus.instr;
        s_addr      = mem_bus.addr;   s_wdata = mem_bus.wdata;
        s_wstrb     = mem_bus.wstrb;  s_timeout = timeout;
        s_busy      = busy;           s_ready0 = m0_bus.ready;
        if (m0_bus.ready === 1'b1) begin
            obs_who.push_back(0); obs_data.push_back(m0_bus.rdata);
            obs_to.push_back(timeout); obs_addr.push_back(mem_bus.addr);
        end
        if (m1_bus.ready === 1'b1) begin
            obs_who.push_back(1); obs_data.push_back(m1_bus.rdata);
            obs_to.push_back(timeout); obs_addr.push_back(mem_bus.addr);
        end
        @(posedge clk);
        #1;
        advance();
        for (int i = 0; i < 2; i++)
            if (e_ready[i]) a_valid[i] = a_reissue[i];
    endtask

    task automatic issue(input int i, input logic instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        a_valid[i] = 1'b1;
        a_instr[i] = instr;
        a_addr[i]  = addr;
        a_wdata[i] = wdata;
        a_wstrb[i] = wstrb;
    endtask

    task automatic clear_obs();
        obs_who.delete(); obs_data.delete(); obs_to.delete(); obs_addr.delete();
    endtask

    task automatic check_done(input string tag, input int idx, input int who,
                              input logic [31:0] data, input logic to);
        check({tag, "_present"}, 32'(obs_who.size() > idx), 32'd1);
        if (obs_who.size() > idx) begin
            check({tag, "_who"},     obs_who[idx],  who);
            check({tag, "_rdata"},   obs_data[idx], data);
            check({tag, "_timeout"}, 32'(obs_to[idx]), 32'(to));
        end
    endtask

    // Assert reset away from the clock edge, confirm every output is already
    // zero, then release on a negedge and realign to posedge+1.
    task automatic apply_reset();
        reset = 1'b0;
        #1;
        check("rst_ctl",      ctl_now(),     32'h0);
        check("rst_mem_addr", mem_bus.addr,  32'h0);
        check("rst_wdata",    mem_bus.wdata, 32'h0);
        check("rst_m0_rdata", m0_bus.rdata,  32'h0);
        check("rst_m1_rdata", m1_bus.rdata,  32'h0);
        for (int i = 0; i < 2; i++) begin
            a_valid[i]   = 1'b0;
            a_reissue[i] = 1'b0;
        end
        mem_ready_r = 1'b0;
        owner = -1; prev_owner = 1; age = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL sim_guard: run exceeded its time budget");
        $fatal(1, "time budget exhausted");
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_valid[i] = 1'b0; a_instr[i] = 1'b0; a_addr[i] = 32'h0;
            a_wdata[i] = 32'h0; a_wstrb[i] = 4'h0; a_reissue[i] = 1'b0;
        end
        mem_ready_r = 1'b0;
        mem_rdata_r = 32'h0;
        #2;
        apply_reset();
        step();

        // ---- Single master-0 read with two downstream wait cycles ----------
        clear_obs();
        issue(0, 1'b0, 32'h100, 32'h0, 4'h0);
        step();
        check("rd_idle_mem_valid", 32'(s_mem_valid), 32'd0);
        step();
        check("rd_mem_valid_rise", 32'(s_mem_valid), 32'd1);
        check("rd_mem_addr",       s_addr,           32'h100);
        step();
        mem_ready_r = 1'b1; mem_rdata_r = 32'h1234_5678;
        step();
        mem_ready_r = 1'b0;
        check("rd_count", obs_who.size(), 1);
        check_done("rd", 0, 0, 32'h1234_5678, 1'b0);
        step();

        // ---- Both masters requesting continuously after reset -------------
        apply_reset();
        clear_obs();
        issue(0, 1'b1, 32'h1000, 32'h0, 4'h0);
        issue(1, 1'b0, 32'h2000, 32'h0, 4'h0);
        a_reissue[0] = 1'b1; a_reissue[1] = 1'b1;
        mem_ready_r = 1'b1; mem_rdata_r = 32'h55aa_0001;
        repeat (8) step();
        check("rr_count", obs_who.size(), 4);
        for (int k = 0; k < 4 && k < obs_who.size(); k++) begin
            check("rr_who",  obs_who[k],  k % 2);
            check("rr_addr", obs_addr[k], (k % 2 == 1) ? 32'h2000 : 32'h1000);
        end
        a_reissue[0] = 1'b0; a_reissue[1] = 1'b0;
        a_valid[0] = 1'b0;   a_valid[1] = 1'b0;
        mem_ready_r = 1'b0;
        step();

        // ---- Master-1 write passthrough -----------------------------------
        clear_obs();
        issue(1, 1'b0, 32'h204, 32'haabb_ccdd, 4'b0011);
        step();
        step();
        check("wr_wstrb", 32'(s_wstrb), 32'h3);
        check("wr_wdata", s_wdata,      32'haabb_ccdd);
        check("wr_addr",  s_addr,       32'h204);
        check("wr_instr", 32'(s_instr), 32'd0);
        mem_ready_r = 1'b1; mem_rdata_r = 32'h0;
        step();
        mem_ready_r = 1'b0;
        check_done("wr", 0, 1, 32'h0, 1'b0);

        // ---- Watchdog abort in BUSY cycle TIMEOUT+1 -----------------------
        clear_obs();
        issue(0, 1'b0, 32'h300, 32'h0, 4'h0);
        step();
        repeat (4) step();
        check("wd_none_early", obs_who.size(), 0);
        step();
        check("wd_timeout",   32'(s_timeout),   32'd1);
        check("wd_mem_valid", 32'(s_mem_valid), 32'd0);
        check_done("wd", 0, 0, ERR, 1'b1);
        step();
        check("wd_back_idle", 32'(s_busy), 32'd0);

        // ---- Same, but mem_ready lands on the expiry cycle ----------------
        clear_obs();
        issue(0, 1'b0, 32'h304, 32'h0, 4'h0);
        step();
        repeat (4) step();
        mem_ready_r = 1'b1; mem_rdata_r = 32'hcafe_f00d;
        step();
        mem_ready_r = 1'b0;
        check("wdr_timeout", 32'(s_timeout), 32'd0);
        check_done("wdr", 0, 0, 32'hcafe_f00d, 1'b0);

        // ---- Reset in the middle of a transaction -------------------------
        issue(0, 1'b0, 32'h400, 32'h0, 4'h0);
        step();
        step();
        mem_ready_r = 1'b1; mem_rdata_r = 32'h7777_7777;
        apply_reset();
        clear_obs();
        issue(0, 1'b0, 32'h410, 32'h0, 4'h0);
        issue(1, 1'b0, 32'h420, 32'h0, 4'h0);
        mem_ready_r = 1'b1; mem_rdata_r = 32'h0bad_f00d;
        repeat (4) step();
        check("rst_tie_count", obs_who.size(), 2);
        check_done("rst_tie", 0, 0, 32'h0bad_f00d, 1'b0);
        mem_ready_r = 1'b0;

        // ---- Master 0 withdraws mid-transaction; master 1 waits -----------
        clear_obs();
        issue(0, 1'b0, 32'h500, 32'h0, 4'h0);
        step();
        step();
        a_valid[0] = 1'b0;
        issue(1, 1'b1, 32'h600, 32'h0, 4'h0);
        step();
        check("pv_mem_valid", 32'(s_mem_valid), 32'd0);
        check("pv_m0_ready",  32'(s_ready0),    32'd0);
        step();
        check("pv_idle", 32'(s_busy), 32'd0);
        check("pv_no_ready", obs_who.size(), 0);
        step();
        check("pv_m1_addr",  s_addr,            32'h600);
        check("pv_m1_valid", 32'(s_mem_valid),  32'd1);
        mem_ready_r = 1'b1; mem_rdata_r = 32'h6666_0000;
        step();
        mem_ready_r = 1'b0;
        check_done("pv", 0, 1, 32'h6666_0000, 1'b0);

        // ---- Randomized traffic -------------------------------------------
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!a_valid[i] && $urandom_range(0, 1) == 1) begin
                    logic [3:0] ws;
                    ws = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                    issue(i, (ws == 4'h0) ? 1'($urandom) : 1'b0,
                          $urandom & 32'hffff_fffc, $urandom, ws);
                end
            end
            mem_ready_r = ($urandom_range(0, 3) == 0);
            mem_rdata_r = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter sharing the single picorv32-style memory port between the CPU core (master 0) and a second requester such as a DMA or debug loader (master 1). It sits between those masters and the memory/bus fabric. It grants one outstanding transaction at a time, using round-robin priority. A watchdog aborts transactions the downstream never completes.

## Interface
Parameters:
- TIMEOUT, 16'd1024, BUSY cycles without mem_ready before abort; 0 disables the watchdog; max 65535
- ERR_DATA, 32'hdead_beef, rdata returned to the master on an aborted transaction

Ports:
- clk  input  1  single clock; all state on posedge
- reset  input  1  asynchronous, active-low reset; low = in reset
- m0_valid / m1_valid  input  1  master request
- m0_instr / m1_instr  input  1  instruction-fetch qualifier
- m0_addr / m1_addr  input  32  byte address, word aligned
- m0_wdata / m1_wdata  input  32  write data
- m0_wstrb / m1_wstrb  input  4  byte write strobes; 0 = read
- m0_ready / m1_ready  output  1  transaction complete (one-cycle pulse)
- m0_rdata / m1_rdata  output  32  read data, valid with ready
- mem_valid  output  1  downstream request
- mem_instr  output  1  forwarded from the granted master
- mem_addr  output  32  forwarded from the granted master
- mem_wdata  output  32  forwarded from the granted master
- mem_wstrb  output  4  forwarded from the granted master
- mem_ready  input  1  downstream completion
- mem_rdata  input  32  downstream read data
- timeout  output  1  high in the cycle an aborted transaction is returned
- busy  output  1  arbiter holds a grant

## Operation
- State machine with states IDLE and BUSY, plus registers grant (1b), last_grant (1b) and wd_cnt (16b).
- In IDLE:
  - No valid: stay in IDLE.
  - One master valid: grant it.
  - Both masters valid: grant the master != last_grant.
  - On a grant: go to BUSY, set last_grant <= grant, clear wd_cnt.
- In BUSY:
  - Downstream outputs are a combinational mux of the granted master's signals.
  - mem_valid = m{grant}_valid && !abort.
  - The ungranted master sees ready=0, and its inputs are ignored.
- Completion: when mem_ready=1 in BUSY, m{grant}_ready=1 and m{grant}_rdata=mem_rdata in the same cycle. Next state is IDLE.
- Watchdog: in BUSY with mem_ready=0, wd_cnt increments.
  - abort = (TIMEOUT!=0) && wd_cnt==TIMEOUT && !mem_ready.
  - On abort: m{grant}_ready=1, rdata=ERR_DATA, timeout=1, mem_valid forced 0, next state IDLE.
  - mem_ready and abort in the same cycle: mem_ready wins; normal completion, timeout=0.
- Master drops valid in BUSY before ready: protocol violation. Go to IDLE next cycle with no ready pulse. mem_valid follows valid and drops immediately.
- rdata to the ungranted master and in IDLE: 32'h0.
- Writes pass through untouched. The arbiter does not inspect or modify wstrb, addr or wdata.

## Timing
- Reset (reset low, asynchronous) clears state and outputs:
  - state=IDLE, grant=0, wd_cnt=0.
  - last_grant=1, so master 0 wins the first tie.
  - All outputs are 0: mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, m*_ready, m*_rdata, timeout, busy.
- Reset deassertion is synchronized by the surrounding design.
- Reset mid-transaction drops mem_valid and ready immediately. No ready pulse is issued.
- Arbitration latency: valid sampled in IDLE at edge N; mem_valid high in cycle N+1.
- Completion latency: m*_ready is combinational from mem_ready, zero added cycles.
- Throughput: back-to-back transactions need one IDLE cycle between them. Minimum 2 cycles per transaction with a zero-wait downstream.
- busy = (state==BUSY), registered.
- Abort occurs in the (TIMEOUT+1)-th BUSY cycle.
- ready and timeout are single-cycle pulses and never held.
- A master must hold valid and payload stable until it sees its ready (picorv32 rule).

## Test plan
- Single master 0 read: m0_valid=1, addr=0x100, downstream returns ready after 2 wait cycles with rdata=0x12345678 → mem_valid rises 1 cycle after request; m0_ready pulses once with rdata=0x12345678; m1_ready stays 0.
- Simultaneous requests after reset: both valid continuously, zero-wait downstream → grants alternate m0, m1, m0, m1; each transaction spans 2 cycles; addresses on mem_addr alternate accordingly.
- Write passthrough: m1_valid=1, wstrb=4'b0011, wdata=0xAABBCCDD, addr=0x204 → mem_wstrb=4'b0011, mem_wdata=0xAABBCCDD, mem_addr=0x204, mem_instr=m1_instr; m1_ready on mem_ready.
- Watchdog with TIMEOUT=4: downstream never ready → m0_ready=1, m0_rdata=0xdeadbeef and timeout=1 in the 5th BUSY cycle; mem_valid=0 that cycle; arbiter returns to IDLE. Repeat with mem_ready arriving on that same cycle → normal completion, timeout=0.
- Reset mid-transaction: assert reset low during BUSY → mem_valid, busy and ready drop immediately with no ready pulse; after release, a tie grants master 0 first.
- Protocol violation: m0_valid drops in BUSY before mem_ready → mem_valid falls the same cycle, no m0_ready pulse, IDLE next cycle; a pending m1 request is then granted.
